// File: rtl/vram_scanout_if.sv
// -----------------------------------------------------------------------------
// vram_scanout_if
//   Read-side bus between the scanout stage and the 1024x8 video RAM.
//
//   Signals:
//     vram_addr  [9:0]  read address, driven by the scanout stage
//     vram_data  [7:0]  read data, valid one clock after vram_addr changes
//
//   Modports:
//     master  scanout side (drives the address, consumes the data)
//     slave   VRAM side (consumes the address, returns the data)
// -----------------------------------------------------------------------------
interface vram_scanout_if;
    logic [9:0] vram_addr;
    logic [7:0] vram_data;

    modport master (output vram_addr, input  vram_data);
    modport slave  (input  vram_addr, output vram_data);
endinterface

// File: rtl/vram_scanout.sv
// -----------------------------------------------------------------------------
// vram_scanout
//   Display scanout stage for a 128x64, 1 bpp framebuffer held in a 1024x8
//   video RAM (16 bytes per line, row-major). Generates raster timing,
//   prefetches each framebuffer byte two clocks ahead of its first pixel and
//   serialises it MSB first. All video outputs are the registered decode of
//   the raster counters, so they share one clock of latency and stay aligned.
//
//   Ports:
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     en           scanout enable; 0 freezes the raster
//     vram         VRAM read bus (master side: vram_addr out, vram_data in)
//     pix          registered pixel value
//     de           registered data enable (active pixels)
//     hsync        registered horizontal sync, active high
//     vsync        registered vertical sync, active high
//     frame_start  one-cycle pulse aligned with the first active pixel
//
//   Build option:
//     VRAM_SCANOUT_DOUBLE_EN  when defined, every framebuffer pixel is shown
//                             as 2x2 (256x128 output timing by default).
// -----------------------------------------------------------------------------
module vram_scanout #(
`ifdef VRAM_SCANOUT_DOUBLE_EN
    parameter int H_ACTIVE = 256,
    parameter int V_ACTIVE = 128,
`else
    parameter int H_ACTIVE = 128,
    parameter int V_ACTIVE = 64,
`endif
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 16,
    parameter int H_BP     = 8,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    vram_scanout_if.master vram,
    output logic           pix,
    output logic           de,
    output logic           hsync,
    output logic           vsync,
    output logic           frame_start
);

`ifdef VRAM_SCANOUT_DOUBLE_EN
    localparam int PIX_SHIFT = 1;   // log2 of the pixel replication factor
`else
    localparam int PIX_SHIFT = 0;
`endif

    localparam int H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W           = $clog2(H_TOTAL);
    localparam int V_W           = $clog2(V_TOTAL);
    localparam int GROUP         = 8 << PIX_SHIFT;      // output clocks per byte
    localparam int SUB_MASK      = (1 << PIX_SHIFT) - 1;
    localparam int BYTES_PER_ROW = 16;

    logic [H_W-1:0] h_cnt, h_next;
    logic [V_W-1:0] v_cnt, v_next;
    logic [7:0]     shreg;
    logic           line_end, active, hs_region, vs_region;
    logic           load, shift, pf_hit;
    logic [9:0]     pf_addr;
    int             h_i, hn_i, v_i, nl_i;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        h_i       = int'(h_cnt);
        v_i       = int'(v_cnt);
        line_end  = (h_i == H_TOTAL - 1);
        h_next    = line_end ? '0 : h_cnt + H_W'(1);
        v_next    = v_cnt;
        if (line_end)
            v_next = (v_i == V_TOTAL - 1) ? '0 : v_cnt + V_W'(1);
        hn_i      = int'(h_next);
        // Line whose first byte the end-of-line prefetch fetches.
        nl_i      = (v_i == V_TOTAL - 1) ? 0 : v_i + 1;

        active    = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
        hs_region = (h_i >= H_ACTIVE + H_FP) && (h_i < H_ACTIVE + H_FP + H_SYNC);
        vs_region = (v_i >= V_ACTIVE + V_FP) && (v_i < V_ACTIVE + V_FP + V_SYNC);

        // The byte for group k lands in the shifter on the clock before its
        // first pixel; group 0 is loaded on the last clock of the previous line.
        load      = line_end || ((h_i < H_ACTIVE - 1) && (h_i % GROUP == GROUP - 1));
        // In 2x mode each bit is held for two clocks, so shift on odd h only.
        shift     = active && !load && ((h_i & SUB_MASK) == SUB_MASK);

        // Address changes as h reaches load-1, giving the RAM its one clock.
        // Lines past the visible area are never addressed, which also keeps
        // every read inside the 1024-byte array.
        pf_hit    = 1'b0;
        pf_addr   = '0;
        if (hn_i == H_TOTAL - 2) begin
            pf_hit  = (nl_i < V_ACTIVE);
            pf_addr = 10'((nl_i >> PIX_SHIFT) * BYTES_PER_ROW);
        end else if ((hn_i < H_ACTIVE - 2) && (hn_i % GROUP == GROUP - 2)
                     && (v_i < V_ACTIVE)) begin
            pf_hit  = 1'b1;
            pf_addr = 10'((v_i >> PIX_SHIFT) * BYTES_PER_ROW + (hn_i + 2) / GROUP);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt          <= '0;
            v_cnt          <= '0;
            vram.vram_addr <= '0;
            shreg          <= '0;
            pix            <= 1'b0;
            de             <= 1'b0;
            hsync          <= 1'b0;
            vsync          <= 1'b0;
            frame_start    <= 1'b0;
        end else if (en) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
            if (pf_hit)
                vram.vram_addr <= pf_addr;
            if (load)
                shreg <= vram.vram_data;
            else if (shift)
                shreg <= {shreg[6:0], 1'b0};
            de          <= active;
            pix         <= active & shreg[7];
            hsync       <= hs_region;
            vsync       <= vs_region;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            // Raster, shifter and address freeze; syncs keep their level so
            // the monitor sees no spurious edges during a pause.
            de          <= 1'b0;
            pix         <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
